l1_tlb_arbiter: RTL and testbench

- Sits between the instruction L1 TLB, the data L1 TLB and the L2 TLB.
- Buffers one miss request per L1 TLB and arbitrates them round-robin onto the single L2 TLB request channel, tagging each request ITLB or DTLB.
- Registers the L2 TLB answer and routes it back to the L1 TLB named by its destination tag.
- The L1 TLBs always accept answers, so the answer path has no backpressure.

---
 rtl/memory_pkg.sv | 35 +++
 rtl/l1_tlb_arbiter_if.sv | 29 ++
 rtl/l1_tlb_arb_slot.sv | 40 ++++
 rtl/l1_tlb_arbiter.sv | 94 +++++++++
 tb/tb_l1_tlb_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_pkg.sv
// Shared memory-subsystem types for the L1/L2 TLB request and answer channels.
package memory_pkg;

  localparam int unsigned VPN_LEN = 27;
  localparam int unsigned PPN_LEN = 44;

  typedef logic [VPN_LEN-1:0] vpn_t;
  typedef logic [PPN_LEN-1:0] ppn_t;

  typedef enum logic {
    TlbArbItlb = 1'b0,
    TlbArbDtlb = 1'b1
  } tlb_arb_tag_e;

  typedef struct packed {
    logic         valid;
    vpn_t         vpn;
    tlb_arb_tag_e origin;
  } l1tlb_l2tlb_req_t;

  typedef struct packed {
    logic         valid;
    tlb_arb_tag_e destination;
    ppn_t         ppn;
    logic [1:0]   page_type;
    logic         exception;
    logic [7:0]   flags;
  } l2tlb_l1tlb_ans_t;

  typedef struct packed {
    logic valid;
    vpn_t vpn;
  } l1tlb_arb_slot_t;

endpackage

// File: rtl/l1_tlb_arbiter_if.sv
// Bundles the L1-side miss handshakes and the L2-side request/answer channel.
interface l1_tlb_arbiter_if;
  import memory_pkg::*;

  logic             itlb_req_valid_i;
  vpn_t             itlb_req_vpn_i;
  logic             itlb_req_rdy_o;
  logic             dtlb_req_valid_i;
  vpn_t             dtlb_req_vpn_i;
  logic             dtlb_req_rdy_o;
  l1tlb_l2tlb_req_t l1tlb_l2tlb_req_o;
  logic             l2tlb_l1tlb_req_rdy_i;
  l2tlb_l1tlb_ans_t l2tlb_l1tlb_ans_i;
  l2tlb_l1tlb_ans_t itlb_ans_o;
  l2tlb_l1tlb_ans_t dtlb_ans_o;

  modport slave (
    input  itlb_req_valid_i, itlb_req_vpn_i, dtlb_req_valid_i, dtlb_req_vpn_i,
    input  l2tlb_l1tlb_req_rdy_i, l2tlb_l1tlb_ans_i,
    output itlb_req_rdy_o, dtlb_req_rdy_o, l1tlb_l2tlb_req_o, itlb_ans_o, dtlb_ans_o
  );

  modport master (
    output itlb_req_valid_i, itlb_req_vpn_i, dtlb_req_valid_i, dtlb_req_vpn_i,
    output l2tlb_l1tlb_req_rdy_i, l2tlb_l1tlb_ans_i,
    input  itlb_req_rdy_o, dtlb_req_rdy_o, l1tlb_l2tlb_req_o, itlb_ans_o, dtlb_ans_o
  );

endinterface

// File: rtl/l1_tlb_arb_slot.sv
// Single-entry miss buffer for one L1 TLB; emptied by a grant from the arbiter.
module l1_tlb_arb_slot
  import memory_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  vpn_t            vpn_i,
  output logic            rdy_o,
  input  logic            grant_i,
  output l1tlb_arb_slot_t slot_o
);

  l1tlb_arb_slot_t slot_q, slot_d;

  // Ready depends only on state, so a granted slot cannot refill in the same cycle.
  assign rdy_o  = !slot_q.valid;
  assign slot_o = slot_q;

  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      slot_d = '0;
    end else if (grant_i) begin
      slot_d.valid = 1'b0;
    end else if (valid_i && !slot_q.valid) begin
      slot_d = '{valid: 1'b1, vpn: vpn_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/l1_tlb_arbiter.sv
// Round-robin arbiter from ITLB/DTLB miss slots onto the L2 TLB, plus answer router.
module l1_tlb_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned VPN_W = 27,
  parameter int unsigned PPN_W = 44
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              abort_i,
  l1_tlb_arbiter_if.slave   tlb_bus
);

  if (VPN_W != VPN_LEN || PPN_W != PPN_LEN) begin : g_width_check
    $error("l1_tlb_arbiter: VPN_W/PPN_W must match memory_pkg VPN_LEN/PPN_LEN");
  end

  l1tlb_arb_slot_t  itlb_slot, dtlb_slot;
  logic             itlb_grant, dtlb_grant, arb_fire;
  l1tlb_l2tlb_req_t req_q, req_d;
  tlb_arb_tag_e     ptr_q, ptr_d;
  l2tlb_l1tlb_ans_t ans_q;

  l1_tlb_arb_slot u_itlb_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (abort_i),
    .valid_i (tlb_bus.itlb_req_valid_i),
    .vpn_i   (tlb_bus.itlb_req_vpn_i),
    .rdy_o   (tlb_bus.itlb_req_rdy_o),
    .grant_i (itlb_grant),
    .slot_o  (itlb_slot)
  );

  l1_tlb_arb_slot u_dtlb_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (abort_i),
    .valid_i (tlb_bus.dtlb_req_valid_i),
    .vpn_i   (tlb_bus.dtlb_req_vpn_i),
    .rdy_o   (tlb_bus.dtlb_req_rdy_o),
    .grant_i (dtlb_grant),
    .slot_o  (dtlb_slot)
  );

  always_comb begin
    ptr_d      = ptr_q;
    req_d      = req_q;
    itlb_grant = 1'b0;
    dtlb_grant = 1'b0;
    arb_fire   = !req_q.valid || tlb_bus.l2tlb_l1tlb_req_rdy_i;
    if (abort_i) begin
      // An accepted request in the abort cycle has already left; clearing is safe.
      req_d = '0;
    end else if (arb_fire) begin
      req_d = '0;
      if (itlb_slot.valid && dtlb_slot.valid) begin
        itlb_grant = (ptr_q == TlbArbItlb);
        dtlb_grant = (ptr_q == TlbArbDtlb);
        ptr_d      = (ptr_q == TlbArbItlb) ? TlbArbDtlb : TlbArbItlb;
      end else begin
        itlb_grant = itlb_slot.valid;
        dtlb_grant = dtlb_slot.valid;
      end
      if (itlb_grant) begin
        req_d = '{valid: 1'b1, vpn: itlb_slot.vpn, origin: TlbArbItlb};
      end else if (dtlb_grant) begin
        req_d = '{valid: 1'b1, vpn: dtlb_slot.vpn, origin: TlbArbDtlb};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q <= '0;
      ptr_q <= TlbArbItlb;
      ans_q <= '0;
    end else begin
      req_q <= req_d;
      ptr_q <= ptr_d;
      ans_q <= tlb_bus.l2tlb_l1tlb_ans_i;
    end
  end

  assign tlb_bus.l1tlb_l2tlb_req_o = req_q;

  always_comb begin
    tlb_bus.itlb_ans_o       = ans_q;
    tlb_bus.dtlb_ans_o       = ans_q;
    tlb_bus.itlb_ans_o.valid = ans_q.valid && (ans_q.destination == TlbArbItlb);
    tlb_bus.dtlb_ans_o.valid = ans_q.valid && (ans_q.destination == TlbArbDtlb);
  end

endmodule

// File: tb/tb_l1_tlb_arbiter.sv
// Directed bench for l1_tlb_arbiter: latency, round-robin, backpressure, answers, abort, reset.
module tb_l1_tlb_arbiter;
  import memory_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  int   checks = 0;
  int   errors = 0;
  int   deliv_a = 0;

  always #5 clk = ~clk;

  l1_tlb_arbiter_if tlb_bus ();

  l1_tlb_arbiter #(
    .VPN_W (27),
    .PPN_W (44)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .abort_i (abort),
    .tlb_bus (tlb_bus)
  );

  // Count every cycle in which the request carrying VPN 0xA is handed to the L2 TLB.
  always @(posedge clk) begin
    if (tlb_bus.l1tlb_l2tlb_req_o.valid && tlb_bus.l2tlb_l1tlb_req_rdy_i &&
        tlb_bus.l1tlb_l2tlb_req_o.vpn == 27'hA) begin
      deliv_a <= deliv_a + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic l1tlb_l2tlb_req_t mk_req(input logic v, input logic [26:0] vpn,
                                              input tlb_arb_tag_e o);
    mk_req = '{valid: v, vpn: vpn, origin: o};
  endfunction

  task automatic chk_req(input string tag, input l1tlb_l2tlb_req_t exp);
    chk(tag, 64'(tlb_bus.l1tlb_l2tlb_req_o), 64'(exp));
  endtask

  task automatic drive(input logic iv, input logic [26:0] ivpn, input logic dv,
                       input logic [26:0] dvpn);
    tlb_bus.itlb_req_valid_i = iv;
    tlb_bus.itlb_req_vpn_i   = ivpn;
    tlb_bus.dtlb_req_valid_i = dv;
    tlb_bus.dtlb_req_vpn_i   = dvpn;
  endtask

  l1tlb_l2tlb_req_t idle_req;
  l2tlb_l1tlb_ans_t ans_exp;

  initial begin
    idle_req = '0;
    rst = 1'b1;
    abort = 1'b0;
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    tlb_bus.l2tlb_l1tlb_req_rdy_i = 1'b1;
    tlb_bus.l2tlb_l1tlb_ans_i     = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk_req("reset_req", idle_req);
    chk("reset_itlb_rdy", 64'(tlb_bus.itlb_req_rdy_o), 64'd1);
    chk("reset_dtlb_rdy", 64'(tlb_bus.dtlb_req_rdy_o), 64'd1);
    chk("reset_itlb_ans", 64'(tlb_bus.itlb_ans_o), 64'd0);
    chk("reset_dtlb_ans", 64'(tlb_bus.dtlb_ans_o), 64'd0);

    // ITLB only: handshake at cycle 0, request at cycle 2
    drive(1'b1, 27'h0ABCDEF, 1'b0, 27'h0);
    tick();
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    chk("itlb_c1_rdy", 64'(tlb_bus.itlb_req_rdy_o), 64'd0);
    chk_req("itlb_c1_req", idle_req);
    tick();
    chk_req("itlb_c2_req", mk_req(1'b1, 27'h0ABCDEF, TlbArbItlb));
    chk("itlb_c2_rdy", 64'(tlb_bus.itlb_req_rdy_o), 64'd1);
    tick();
    chk_req("itlb_c3_idle", idle_req);

    // Both valid, pointer ITLB-first
    drive(1'b1, 27'h1, 1'b1, 27'h2);
    tick();
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    tick();
    chk_req("rr1_first", mk_req(1'b1, 27'h1, TlbArbItlb));
    tick();
    chk_req("rr1_second", mk_req(1'b1, 27'h2, TlbArbDtlb));
    tick();
    chk_req("rr1_idle", idle_req);

    // Both valid again: pointer flipped, DTLB first
    drive(1'b1, 27'h4, 1'b1, 27'h5);
    tick();
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    tick();
    chk_req("rr2_first", mk_req(1'b1, 27'h5, TlbArbDtlb));
    tick();
    chk_req("rr2_second", mk_req(1'b1, 27'h4, TlbArbItlb));
    tick();
    chk_req("rr2_idle", idle_req);

    // Backpressure with DTLB 0x3 pending, ITLB fills and waits
    tlb_bus.l2tlb_l1tlb_req_rdy_i = 1'b0;
    drive(1'b0, 27'h0, 1'b1, 27'h3);
    tick();
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    tick();
    chk_req("bp_out", mk_req(1'b1, 27'h3, TlbArbDtlb));
    chk("bp_dtlb_rdy", 64'(tlb_bus.dtlb_req_rdy_o), 64'd1);
    drive(1'b1, 27'h6, 1'b0, 27'h0);
    tick();
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    chk("bp_itlb_rdy", 64'(tlb_bus.itlb_req_rdy_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_req("bp_hold", mk_req(1'b1, 27'h3, TlbArbDtlb));
    end
    tlb_bus.l2tlb_l1tlb_req_rdy_i = 1'b1;
    tick();
    chk_req("bp_release_next", mk_req(1'b1, 27'h6, TlbArbItlb));
    chk("bp_release_itlb_rdy", 64'(tlb_bus.itlb_req_rdy_o), 64'd1);
    tick();
    chk_req("bp_idle", idle_req);

    // Answer routing to DTLB, then to ITLB
    ans_exp = '{valid: 1'b1, destination: TlbArbDtlb, ppn: 44'h123, page_type: 2'd1,
                exception: 1'b0, flags: 8'h5A};
    tlb_bus.l2tlb_l1tlb_ans_i = ans_exp;
    tick();
    tlb_bus.l2tlb_l1tlb_ans_i = '0;
    chk("ans_dtlb", 64'(tlb_bus.dtlb_ans_o), 64'(ans_exp));
    chk("ans_dtlb_itlb_valid", 64'(tlb_bus.itlb_ans_o.valid), 64'd0);
    chk("ans_dtlb_itlb_ppn", 64'(tlb_bus.itlb_ans_o.ppn), 64'h123);
    tick();
    chk("ans_dtlb_gone", 64'(tlb_bus.dtlb_ans_o.valid), 64'd0);
    tlb_bus.l2tlb_l1tlb_ans_i = '{valid: 1'b1, destination: TlbArbItlb, ppn: 44'hABC,
                                  page_type: 2'd0, exception: 1'b1, flags: 8'h00};
    tick();
    tlb_bus.l2tlb_l1tlb_ans_i = '0;
    chk("ans_itlb_valid", 64'(tlb_bus.itlb_ans_o.valid), 64'd1);
    chk("ans_itlb_ppn", 64'(tlb_bus.itlb_ans_o.ppn), 64'hABC);
    chk("ans_itlb_dtlb_valid", 64'(tlb_bus.dtlb_ans_o.valid), 64'd0);

    // Abort with both slots full and output stalled
    tlb_bus.l2tlb_l1tlb_req_rdy_i = 1'b0;
    drive(1'b1, 27'h7, 1'b1, 27'h8);
    tick();
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    tick();
    chk_req("ab_out", mk_req(1'b1, 27'h7, TlbArbItlb));
    drive(1'b1, 27'h9, 1'b0, 27'h0);
    tick();
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    chk("ab_full_itlb", 64'(tlb_bus.itlb_req_rdy_o), 64'd0);
    chk("ab_full_dtlb", 64'(tlb_bus.dtlb_req_rdy_o), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_req("ab_req_clr", idle_req);
    chk("ab_itlb_rdy", 64'(tlb_bus.itlb_req_rdy_o), 64'd1);
    chk("ab_dtlb_rdy", 64'(tlb_bus.dtlb_req_rdy_o), 64'd1);
    tick();
    chk_req("ab_still_idle", idle_req);

    // Abort in the cycle the output is accepted; DTLB handshake in that cycle dropped
    drive(1'b1, 27'hA, 1'b0, 27'h0);
    tick();
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    tick();
    chk_req("aba_out", mk_req(1'b1, 27'hA, TlbArbItlb));
    tlb_bus.l2tlb_l1tlb_req_rdy_i = 1'b1;
    abort = 1'b1;
    drive(1'b0, 27'h0, 1'b1, 27'hB);
    tick();
    abort = 1'b0;
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    chk_req("aba_req_clr", idle_req);
    chk("aba_dtlb_rdy", 64'(tlb_bus.dtlb_req_rdy_o), 64'd1);
    tick();
    tick();
    chk("aba_delivered_once", 64'(deliv_a), 64'd1);
    chk_req("aba_no_dtlb", idle_req);

    // Pointer unchanged by abort: still DTLB-first after the earlier double grant
    drive(1'b1, 27'hC, 1'b1, 27'hD);
    tick();
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    tick();
    chk_req("ptr_keep_first", mk_req(1'b1, 27'hD, TlbArbDtlb));
    tick();
    chk_req("ptr_keep_second", mk_req(1'b1, 27'hC, TlbArbItlb));
    tick();

    // Reset mid-backpressure with pointer at DTLB, answer during reset
    drive(1'b1, 27'h10, 1'b1, 27'h11);
    tick();
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    tlb_bus.l2tlb_l1tlb_req_rdy_i = 1'b0;
    tick();
    chk_req("rs_out", mk_req(1'b1, 27'h10, TlbArbItlb));
    tick();
    chk("rs_dtlb_wait", 64'(tlb_bus.dtlb_req_rdy_o), 64'd0);
    rst = 1'b1;
    tlb_bus.l2tlb_l1tlb_ans_i = '{valid: 1'b1, destination: TlbArbItlb, ppn: 44'h55,
                                  page_type: 2'd2, exception: 1'b0, flags: 8'hFF};
    tick();
    chk_req("rs_req", idle_req);
    chk("rs_itlb_rdy", 64'(tlb_bus.itlb_req_rdy_o), 64'd1);
    chk("rs_dtlb_rdy", 64'(tlb_bus.dtlb_req_rdy_o), 64'd1);
    chk("rs_itlb_ans", 64'(tlb_bus.itlb_ans_o), 64'd0);
    chk("rs_dtlb_ans", 64'(tlb_bus.dtlb_ans_o), 64'd0);
    rst = 1'b0;
    tlb_bus.l2tlb_l1tlb_ans_i = '0;
    tlb_bus.l2tlb_l1tlb_req_rdy_i = 1'b1;
    drive(1'b1, 27'h12, 1'b1, 27'h13);
    tick();
    drive(1'b0, 27'h0, 1'b0, 27'h0);
    tick();
    chk_req("rs_ptr_first", mk_req(1'b1, 27'h12, TlbArbItlb));
    tick();
    chk_req("rs_ptr_second", mk_req(1'b1, 27'h13, TlbArbDtlb));
    tick();
    chk_req("rs_idle", idle_req);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
